// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
//   Owns the register file's single write port and shares it between the
//   pipeline writeback stage and a long-latency (LL) unit.
//   - The writeback stage has priority and is never stalled. A writeback to
//     x0 does not claim the port.
//   - The LL unit uses a valid/ready handshake and is accepted whenever
//     writeback leaves the port free.
//   - A scoreboard tracks destination registers with LL ops in flight.
//     Decode uses it to detect RAW/WAW hazards.
//   - A starvation counter raises pipe_stall so that the pipeline injects a
//     bubble and the pending LL result can drain.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous, active-low reset
//   wb_valid     pipeline writeback has a result this cycle
//   wb_rd        pipeline destination register
//   wb_data      pipeline result
//   ll_valid     LL result pending (held stable until accepted)
//   ll_rd        LL destination register
//   ll_data      LL result
//   ll_ready     LL result accepted this cycle
//   issue_valid  decode issues an op to the LL unit
//   issue_rd     destination of the issued LL op
//   issue_ready  issue accepted
//   dec_rs1      decode source 1
//   dec_rs2      decode source 2
//   dec_rd       decode destination
//   dec_hazard   decode must stall on a busy register
//   pipe_stall   starvation request: freeze fetch/decode issue
//   busy         scoreboard vector, bit 0 always 0
//   RegWrite     register file write enable
//   WriteAddr    register file write address
//   WriteData    register file write data

module rf_write_scheduler #(
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned MAX_OUT      = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DW-1:0]     wb_data,
    input  logic              ll_valid,
    input  logic [AW-1:0]     ll_rd,
    input  logic [DW-1:0]     ll_data,
    output logic              ll_ready,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic [AW-1:0]     dec_rs1,
    input  logic [AW-1:0]     dec_rs2,
    input  logic [AW-1:0]     dec_rd,
    output logic              dec_hazard,
    output logic              pipe_stall,
    output logic [2**AW-1:0]  busy,
    output logic              RegWrite,
    output logic [AW-1:0]     WriteAddr,
    output logic [DW-1:0]     WriteData
);

    localparam int unsigned NREG = 2**AW;
    localparam int unsigned CW   = $clog2(MAX_OUT + 1);
    localparam int unsigned WW   = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]   out_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [NREG-1:0] busy_next;
    logic            pw;
    logic            ll_accept;
    logic            issue_accept;

    // ------------------------------------------------------------------
    // Write-port arbitration: combinational, reaches the reg file in the
    // same cycle. pipe_stall has no effect here; it only keeps decode
    // from refilling WB, so the LL result wins on the next bubble.
    // ------------------------------------------------------------------
    always_comb begin
        pw        = wb_valid && (wb_rd != '0);
        ll_ready  = ll_valid && !pw;
        RegWrite  = 1'b0;
        WriteAddr = '0;
        WriteData = '0;
        if (pw) begin
            RegWrite  = 1'b1;
            WriteAddr = wb_rd;
            WriteData = wb_data;
        end else if (ll_valid) begin
            RegWrite  = (ll_rd != '0);
            WriteAddr = ll_rd;
            WriteData = ll_data;
        end
    end

    assign ll_accept = ll_valid && ll_ready;

    // ------------------------------------------------------------------
    // Scoreboard
    // issue_ready is independent of every *_valid, so the decode stage
    // can use it without creating a combinational loop.
    // ------------------------------------------------------------------
    assign issue_ready  = (out_cnt < CW'(MAX_OUT)) && !busy[issue_rd];
    assign issue_accept = issue_valid && issue_ready;
    assign dec_hazard   = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

    // An issue and a retire never target the same index, because a busy
    // destination blocks issue. Therefore the order of clear and set
    // below does not matter.
    always_comb begin
        busy_next = busy;
        if (ll_accept)
            busy_next[ll_rd] = 1'b0;
        if (issue_accept && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= '0;
            out_cnt <= '0;
        end else begin
            busy <= busy_next;
            case ({issue_accept, ll_accept})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                // A retire with nothing outstanding is a protocol error.
                // Hold the count at zero instead of wrapping.
                2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation: count the cycles an LL result waits behind writeback.
    // The counter saturates at STARVE_LIMIT. Once it reaches the limit,
    // the next edge raises pipe_stall. The stall drops on the edge after
    // the LL result is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= '0;
            pipe_stall <= 1'b0;
        end else if (!ll_valid || ll_accept) begin
            wait_cnt   <= '0;
            pipe_stall <= 1'b0;
        end else begin
            if (wait_cnt != WW'(STARVE_LIMIT))
                wait_cnt <= wait_cnt + WW'(1);
            if (wait_cnt == WW'(STARVE_LIMIT))
                pipe_stall <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic              clk;
    logic              rst;
    logic              wb_valid;
    logic [AW-1:0]     wb_rd;
    logic [DW-1:0]     wb_data;
    logic              ll_valid;
    logic [AW-1:0]     ll_rd;
    logic [DW-1:0]     ll_data;
    logic              ll_ready;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              issue_ready;
    logic [AW-1:0]     dec_rs1;
    logic [AW-1:0]     dec_rs2;
    logic [AW-1:0]     dec_rd;
    logic              dec_hazard;
    logic              pipe_stall;
    logic [2**AW-1:0]  busy;
    logic              RegWrite;
    logic [AW-1:0]     WriteAddr;
    logic [DW-1:0]     WriteData;

    int n_vec = 0;
    int n_err = 0;

    rf_write_scheduler #(
        .DW(DW),
        .AW(AW),
        .MAX_OUT(4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .ll_valid(ll_valid),
        .ll_rd(ll_rd),
        .ll_data(ll_data),
        .ll_ready(ll_ready),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2),
        .dec_rd(dec_rd),
        .dec_hazard(dec_hazard),
        .pipe_stall(pipe_stall),
        .busy(busy),
        .RegWrite(RegWrite),
        .WriteAddr(WriteAddr),
        .WriteData(WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        ll_valid    = 1'b0;
        ll_rd       = '0;
        ll_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("init_busy",  64'(busy),        64'h0);
        check("init_stall", 64'(pipe_stall),  64'h0);
        check("init_iss_rdy", 64'(issue_ready), 64'h1);
        check("init_regwr", 64'(RegWrite),    64'h0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // WB only
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        check("wb_regwr", 64'(RegWrite),  64'h1);
        check("wb_addr",  64'(WriteAddr), 64'h5);
        check("wb_data",  64'(WriteData), 64'hDEADBEEF);
        check("wb_llrdy", 64'(ll_ready),  64'h0);
        // WB to x0 does not claim the port; LL to x0 does not write.
        wb_rd = 5'd0; ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h55;
        #1;
        check("wbx0_llrdy", 64'(ll_ready), 64'h1);
        check("wbx0_regwr", 64'(RegWrite), 64'h0);
        idle_inputs();
        #1;
        check("idle_regwr", 64'(RegWrite),  64'h0);
        check("idle_data",  64'(WriteData), 64'h0);
        tick();

        // Scoreboard: issue 7, hazard, retire 7
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        check("sb_iss_rdy", 64'(issue_ready), 64'h1);
        tick();
        issue_valid = 1'b0;
        dec_rs1 = 5'd7;
        #1;
        check("sb_busy7",  64'(busy),       64'h80);
        check("sb_haz_rs1", 64'(dec_hazard), 64'h1);
        dec_rs1 = 5'd1; dec_rd = 5'd7;
        #1;
        check("sb_haz_rd", 64'(dec_hazard), 64'h1);
        dec_rd = 5'd2; dec_rs2 = 5'd3;
        #1;
        check("sb_nohaz",  64'(dec_hazard), 64'h0);
        dec_rs1 = 5'd7;
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
        #1;
        check("sb_llrdy",  64'(ll_ready),  64'h1);
        check("sb_regwr",  64'(RegWrite),  64'h1);
        check("sb_addr",   64'(WriteAddr), 64'h7);
        check("sb_data",   64'(WriteData), 64'h1234);
        tick();
        ll_valid = 1'b0;
        #1;
        check("sb_busy_clr", 64'(busy),       64'h0);
        check("sb_haz_clr",  64'(dec_hazard), 64'h0);
        idle_inputs();

        // Conflict: WB rd3 and LL rd9 together
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA0A0A0A0;
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'hB9B9B9B9;
        #1;
        check("cf_addr_wb", 64'(WriteAddr), 64'h3);
        check("cf_data_wb", 64'(WriteData), 64'hA0A0A0A0);
        check("cf_llrdy0",  64'(ll_ready),  64'h0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("cf_addr_ll", 64'(WriteAddr), 64'h9);
        check("cf_data_ll", 64'(WriteData), 64'hB9B9B9B9);
        check("cf_regwr",   64'(RegWrite),  64'h1);
        check("cf_llrdy1",  64'(ll_ready),  64'h1);
        tick();
        idle_inputs();
        #1;
        check("cf_busy", 64'(busy), 64'h0);

        // Starvation
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
        #1;
        check("st_addr", 64'(WriteAddr), 64'h4);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("st_early%0d", k), 64'(pipe_stall), 64'h0);
        end
        tick();
        check("st_set",  64'(pipe_stall), 64'h1);
        tick();
        check("st_hold", 64'(pipe_stall), 64'h1);
        wb_valid = 1'b0;
        #1;
        check("st_llrdy", 64'(ll_ready),  64'h1);
        check("st_lladdr", 64'(WriteAddr), 64'h7);
        tick();
        idle_inputs();
        check("st_clr",  64'(pipe_stall), 64'h0);
        check("st_busy", 64'(busy),       64'h0);

        // Asynchronous reset in the middle of a cycle
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd4;
        ll_valid = 1'b1; ll_rd = 5'd7;
        for (int k = 0; k < 9; k++) tick();
        issue_rd = 5'd7;
        #1;
        check("rs_pre_stall", 64'(pipe_stall),  64'h1);
        check("rs_pre_busy",  64'(busy),        64'h80);
        check("rs_pre_rdy",   64'(issue_ready), 64'h0);
        rst = 1'b0;
        #1;
        check("rs_busy",  64'(busy),        64'h0);
        check("rs_stall", 64'(pipe_stall),  64'h0);
        check("rs_rdy",   64'(issue_ready), 64'h1);
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_rd = AW'(r);
            #1;
            check($sformatf("lim_rdy%0d", r), 64'(issue_ready), 64'h1);
            tick();
        end
        issue_rd = 5'd5;
        #1;
        check("lim_full", 64'(issue_ready), 64'h0);
        issue_valid = 1'b0;
        ll_valid = 1'b1; ll_rd = 5'd4;
        tick();
        ll_rd = 5'd3;
        tick();
        ll_valid = 1'b0;
        #1;
        check("lim_busy2", 64'(busy), 64'h6);
        issue_valid = 1'b1; issue_rd = 5'd5;
        ll_valid = 1'b1; ll_rd = 5'd1;
        #1;
        check("lim_same_irdy", 64'(issue_ready), 64'h1);
        check("lim_same_lrdy", 64'(ll_ready),    64'h1);
        tick();
        idle_inputs();
        issue_rd = 5'd2;
        #1;
        check("lim_busy_swap", 64'(busy),        64'h24);
        check("lim_busy_blk",  64'(issue_ready), 64'h0);
        issue_valid = 1'b1; issue_rd = 5'd6;
        #1;
        check("lim_cnt3", 64'(issue_ready), 64'h1);
        tick();
        issue_rd = 5'd8;
        #1;
        check("lim_cnt4", 64'(issue_ready), 64'h1);
        tick();
        issue_rd = 5'd10;
        #1;
        check("lim_cnt_full", 64'(issue_ready), 64'h0);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
